// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared widths, sizes and types for the CPU register file
package reg_file_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int NREGS      = 2 ** DEF_ADDR_W;

    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef logic [DEF_DATA_W-1:0] word_t;
    typedef logic [DEF_ADDR_W-1:0] regaddr_t;

endpackage

// File: rtl/reg_file_rport.sv
// rtl/reg_file_rport.sv - combinational read port with hardwired zero register
// Optional write-through forwarding under REGFILE_WRITE_BYPASS_EN.
module reg_file_rport
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREGS  = 2 ** ADDR_W
) (
    input  logic [DATA_W-1:0] regs [1:NREGS-1],
    input  logic [ADDR_W-1:0] rn,
`ifdef REGFILE_WRITE_BYPASS_EN
    input  logic              clrn,
    input  logic              we,
    input  logic [ADDR_W-1:0] wn,
    input  logic [DATA_W-1:0] d,
`endif
    output logic [DATA_W-1:0] q
);

    always_comb begin
        q = '0;
        if (rn != ADDR_W'(ZERO_REG)) begin
            q = regs[rn];
        end
`ifdef REGFILE_WRITE_BYPASS_EN
        // Forward the in-flight write so a same-cycle reader sees the new value.
        if (clrn && we && (wn != ADDR_W'(ZERO_REG)) && (wn == rn)) begin
            q = d;
        end
`endif
    end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 register file, two combinational reads, one clocked write
// Read-port forwarding is enabled by defining REGFILE_WRITE_BYPASS_EN.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [ADDR_W-1:0] rna,
    input  logic [ADDR_W-1:0] rnb,
    input  logic [DATA_W-1:0] d,
    input  logic [ADDR_W-1:0] wn,
    input  logic              we,
    output logic [DATA_W-1:0] qa,
    output logic [DATA_W-1:0] qb
);

    localparam int N = 2 ** ADDR_W;

    // Entry 0 has no storage; the read ports synthesise it as zero.
    logic [DATA_W-1:0] regs [1:N-1];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 1; i < N; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wn != ADDR_W'(ZERO_REG))) begin
            regs[wn] <= d;
        end
    end

    reg_file_rport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (N)
    ) u_rport_a (
        .regs (regs),
        .rn   (rna),
`ifdef REGFILE_WRITE_BYPASS_EN
        .clrn (clrn),
        .we   (we),
        .wn   (wn),
        .d    (d),
`endif
        .q    (qa)
    );

    reg_file_rport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (N)
    ) u_rport_b (
        .regs (regs),
        .rn   (rnb),
`ifdef REGFILE_WRITE_BYPASS_EN
        .clrn (clrn),
        .we   (we),
        .wn   (wn),
        .d    (d),
`endif
        .q    (qb)
    );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file
module tb_reg_file;
    import reg_file_pkg::*;

    logic     clk;
    logic     clrn;
    regaddr_t rna;
    regaddr_t rnb;
    word_t    d;
    regaddr_t wn;
    logic     we;
    word_t    qa;
    word_t    qb;

    int n_checks;
    int n_errors;

    reg_file dut (
        .clk  (clk),
        .clrn (clrn),
        .rna  (rna),
        .rnb  (rnb),
        .d    (d),
        .wn   (wn),
        .we   (we),
        .qa   (qa),
        .qb   (qb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        word_t exp_a;
        word_t exp_b;
        n_checks = 0;
        n_errors = 0;
        clrn = 1'b0;
        we   = 1'b0;
        wn   = '0;
        d    = '0;
        rna  = 5'd1;
        rnb  = 5'd5;

        #100;
        check("reset_qa", qa, 32'h0);
        check("reset_qb", qb, 32'h0);

        // Writes attempted while reset is held must be ignored.
        we = 1'b1;
        wn = 5'd1;
        d  = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        check("reset_wr_qa", qa, 32'h0);
        wn = 5'd5;
        @(posedge clk);
        #1;
        check("reset_wr_qb", qb, 32'h0);

        @(negedge clk);
        clrn = 1'b1;
        for (int k = 1; k < 32; k++) begin
            wn = regaddr_t'(k);
            d  = word_t'(k * 3);
            @(negedge clk);
        end
        we = 1'b0;

        for (int k = 0; k < 32; k++) begin
            rna = regaddr_t'(k);
            rnb = regaddr_t'(31 - k);
            #1;
            exp_a = (k == 0) ? 32'h0 : word_t'(k * 3);
            exp_b = (k == 31) ? 32'h0 : word_t'((31 - k) * 3);
            check($sformatf("fill_qa[%0d]", k), qa, exp_a);
            check($sformatf("fill_qb[%0d]", 31 - k), qb, exp_b);
        end

        rna = 5'd3;
        rnb = 5'd3;
        #1;
        check("same_addr_qa", qa, 32'd9);
        check("same_addr_qb", qb, 32'd9);

        @(negedge clk);
        we  = 1'b1;
        wn  = 5'd0;
        d   = 32'hDEAD_BEEF;
        rna = 5'd0;
        @(posedge clk);
        #1;
        check("zero_reg", qa, 32'h0);

        @(negedge clk);
        we  = 1'b0;
        wn  = 5'd5;
        d   = 32'h1234_5678;
        rnb = 5'd5;
        @(posedge clk);
        #1;
        check("we_low", qb, 32'd15);

        @(negedge clk);
        rna = 5'd7;
        wn  = 5'd7;
        we  = 1'b1;
        d   = 32'hA5A5_A5A5;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        check("rdw_before", qa, 32'hA5A5_A5A5);
`else
        check("rdw_before", qa, 32'd21);
`endif
        check("rdw_other_port", qb, 32'd15);
        @(posedge clk);
        #1;
        check("rdw_after", qa, 32'hA5A5_A5A5);

        @(negedge clk);
        we  = 1'b0;
        rna = 5'd10;
        rnb = 5'd31;
        #1;
        check("pre_rst_qa", qa, 32'd30);
        check("pre_rst_qb", qb, 32'd93);
        #1;
        clrn = 1'b0;
        #1;
        check("async_rst_qa", qa, 32'h0);
        check("async_rst_qb", qb, 32'h0);
        clrn = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_qa", qa, 32'h0);
        check("post_rst_qb", qb, 32'h0);

        @(negedge clk);
        we = 1'b1;
        wn = 5'd10;
        d  = 32'd77;
        @(posedge clk);
        #1;
        check("rewrite_qa", qa, 32'd77);
        check("rewrite_qb", qb, 32'h0);

        // Reset overlapping a write edge wins.
        @(negedge clk);
        wn   = 5'd31;
        d    = 32'hCAFE_F00D;
        clrn = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_wr_qb", qb, 32'h0);
        check("rst_mid_wr_qa", qa, 32'h0);
        @(negedge clk);
        we   = 1'b0;
        clrn = 1'b1;
        #1;
        check("rst_mid_wr_hold", qb, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
